// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift right, shift left or parallel load, with
// a shift counter that wraps every WIDTH shifts and pulses word_done afterwards.
module shift_register_universal #(
    parameter int WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       shift,
    input  logic [1:0]                 mode,
    input  logic                       serial_in,
    input  logic [WIDTH-1:0]           parallel_in,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       serial_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       word_done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] data;
    logic [CW-1:0]    count;
    logic             dir;
    logic             done;

    // Any shift in either direction advances the count; the last one of a word wraps it.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur);
        return (cur == LAST) ? '0 : cur + CW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift) begin
                case (mode)
                    MODE_RIGHT: begin
                        data  <= {serial_in, data[WIDTH-1:1]};
                        dir   <= 1'b0;
                        count <= next_count(count);
                        done  <= (count == LAST);
                    end
                    MODE_LEFT: begin
                        data  <= {data[WIDTH-2:0], serial_in};
                        dir   <= 1'b1;
                        count <= next_count(count);
                        done  <= (count == LAST);
                    end
                    MODE_LOAD: begin
                        data  <= parallel_in;
                        count <= '0;
                    end
                    MODE_HOLD: ;
                    default:   ;
                endcase
            end
        end
    end

    // The outgoing bit depends on which end the most recent shift drained from.
    assign serial_out   = dir ? data[WIDTH-1] : data[0];
    assign parallel_out = data;
    assign bit_count    = count;
    assign word_done    = done;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal at WIDTH=4 with hand-computed
// expected values for loads, shifts in both directions, wraps, reset and hold.
module tb_shift_register_universal;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             shift;
    logic [1:0]       mode;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic [2:0]       bit_count;
    logic             word_done;

    int n_checks = 0;
    int n_pass   = 0;

    shift_register_universal #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .shift       (shift),
        .mode        (mode),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .parallel_out(parallel_out),
        .serial_out  (serial_out),
        .bit_count   (bit_count),
        .word_done   (word_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic op(input logic r, input logic s, input logic [1:0] m,
                      input logic si, input logic [3:0] pi);
        reset = r; shift = s; mode = m; serial_in = si; parallel_in = pi;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [3:0] po, input logic so,
                              input logic [2:0] bc, input logic wd);
        check({tag, ".po"}, parallel_out, po);
        check({tag, ".so"}, serial_out, so);
        check({tag, ".bc"}, bit_count, bc);
        check({tag, ".wd"}, word_done, wd);
    endtask

    logic [3:0] exp_po_r [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    logic       exp_so_r [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       sin_l    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_po_l [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
    int pulses;

    initial begin
        reset = 1'b1; shift = 1'b0; mode = 2'b00; serial_in = 1'b0; parallel_in = '0;
        @(posedge clock); #1;

        // Reset with garbage-free inputs, then load and drain right.
        op(1, 0, 2'b00, 0, 4'h0);
        expect_all("reset", 4'b0000, 0, 0, 0);
        op(0, 1, 2'b11, 1, 4'b1010);
        expect_all("load1010", 4'b1010, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 2'b01, 0, 4'hF);
            expect_all($sformatf("shr%0d", i + 1), exp_po_r[i], exp_so_r[i],
                       3'((i + 1) % 4), (i == 3));
        end
        op(0, 0, 2'b01, 0, 4'h0);
        check("shr_after.wd", word_done, 0);

        // Shift left from zero with serial pattern 1,1,0,1.
        op(1, 0, 2'b00, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 2'b10, sin_l[i], 4'h0);
            expect_all($sformatf("shl%0d", i + 1), exp_po_l[i], exp_po_l[i][3],
                       3'((i + 1) % 4), (i == 3));
        end
        op(0, 0, 2'b00, 0, 4'h0);
        check("shl_after.wd", word_done, 0);

        // Load keeps the left direction; then mixed right/left shifts keep counting.
        op(0, 1, 2'b11, 0, 4'b1000);
        expect_all("load1000", 4'b1000, 1, 0, 0);
        op(0, 1, 2'b01, 0, 4'h0);
        expect_all("mix_r", 4'b0100, 0, 1, 0);
        op(0, 1, 2'b10, 1, 4'h0);
        expect_all("mix_l", 4'b1001, 1, 2, 0);

        // Load at count 3 clears the count without a word_done pulse.
        op(1, 0, 2'b00, 0, 4'h0);
        for (int i = 0; i < 3; i++) op(0, 1, 2'b01, 0, 4'h0);
        check("pre_load.bc", bit_count, 3);
        op(0, 1, 2'b11, 0, 4'b1111);
        expect_all("load_at3", 4'b1111, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 2'b01, 0, 4'h0);
            if (word_done) pulses++;
        end
        op(0, 0, 2'b00, 0, 4'h0);
        if (word_done) pulses++;
        check("load_at3.pulses", pulses, 1);
        check("load_at3.po", parallel_out, 4'b0000);

        // Back-to-back words give word_done on the 4th and 8th edges only.
        op(1, 0, 2'b00, 0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            op(0, 1, 2'b10, 1, 4'h0);
            check($sformatf("b2b%0d.wd", i + 1), word_done, (i == 3 || i == 7));
        end
        check("b2b.po", parallel_out, 4'b1111);

        // Reset wins over a shift and discards the partial count.
        op(1, 0, 2'b00, 0, 4'h0);
        op(0, 1, 2'b01, 1, 4'h0);
        op(0, 1, 2'b01, 1, 4'h0);
        expect_all("pre_rst", 4'b1100, 0, 2, 0);
        op(1, 1, 2'b01, 1, 4'hF);
        expect_all("rst_prio", 4'b0000, 0, 0, 0);

        // Hold: shift=0 with every mode, and shift=1 with mode 00.
        op(0, 1, 2'b11, 0, 4'b0110);
        op(0, 1, 2'b10, 0, 4'h0);
        expect_all("pre_hold", 4'b1100, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            op(0, 0, 2'(i), 1, 4'b1011);
            expect_all($sformatf("hold%0d", i), 4'b1100, 1, 1, 0);
        end
        op(0, 1, 2'b00, 1, 4'b1011);
        expect_all("hold_m00", 4'b1100, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
